// File: rtl/slave_uart_link.sv
// Two-wire (sig + bs) serial link slave: independent oversampling receiver
// and fixed-cadence transmitter with a guard gap between outgoing frames.
module slave_uart_link #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned BIT_CLKS = 100,
    parameter int unsigned GAP_CLKS = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bs_in,
    input  logic             sig_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_err,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_start,
    output logic             tx_busy,
    output logic             bs_out,
    output logic             sig_out
);

    localparam int unsigned CELL_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(BIT_CLKS - 1);
    localparam logic [CELL_W-1:0] CELL_MID  = CELL_W'(BIT_CLKS / 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);

    typedef enum logic {R_IDLE, R_BITS} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_state_t;

    // Synchronizers; sync_vld marks which stages hold post-reset samples so a
    // line already high when reset releases is never mistaken for a rising edge.
    logic       bs_s1, bs_s2, sig_s1, sig_s2, sig_prev;
    logic [2:0] sync_vld;
    logic       sig_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            bs_s1    <= 1'b0;
            bs_s2    <= 1'b0;
            sig_s1   <= 1'b0;
            sig_s2   <= 1'b0;
            sig_prev <= 1'b0;
            sync_vld <= 3'b000;
        end else begin
            bs_s1    <= bs_in;
            bs_s2    <= bs_s1;
            sig_s1   <= sig_in;
            sig_s2   <= sig_s1;
            sig_prev <= sig_s2;
            sync_vld <= {sync_vld[1:0], 1'b1};
        end
    end

    assign sig_rise = sync_vld[2] & sig_s2 & ~sig_prev;

    // Receiver
    rx_state_t         rx_state, rx_state_nxt;
    logic [CELL_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [IDX_W-1:0]  rx_idx, rx_idx_nxt;
    logic [WIDTH-1:0]  rx_word, rx_word_nxt;
    logic [WIDTH-1:0]  rx_data_nxt;
    logic              rx_valid_nxt, rx_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_word  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_word  <= rx_word_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            rx_err   <= rx_err_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_word_nxt  = rx_word;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        rx_err_nxt   = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (sig_rise) begin
                    rx_state_nxt = R_BITS;
                    rx_cnt_nxt   = '0;
                    rx_idx_nxt   = '0;
                end
            end
            R_BITS: begin
                if (!sig_s2) begin
                    rx_err_nxt   = 1'b1;
                    rx_state_nxt = R_IDLE;
                    rx_cnt_nxt   = '0;
                    rx_idx_nxt   = '0;
                end else if (rx_cnt == CELL_MID && rx_idx == IDX_LAST) begin
                    rx_word_nxt[rx_idx] = bs_s2;
                    rx_data_nxt         = rx_word_nxt;
                    rx_valid_nxt        = 1'b1;
                    rx_state_nxt        = R_IDLE;
                    rx_cnt_nxt          = '0;
                    rx_idx_nxt          = '0;
                end else begin
                    if (rx_cnt == CELL_MID) begin
                        rx_word_nxt[rx_idx] = bs_s2;
                    end
                    if (rx_cnt == CELL_LAST) begin
                        rx_cnt_nxt = '0;
                        rx_idx_nxt = rx_idx + IDX_W'(1);
                    end else begin
                        rx_cnt_nxt = rx_cnt + CELL_W'(1);
                    end
                end
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // Transmitter; outputs are registered so the line shows the current cell.
    tx_state_t         tx_state, tx_state_nxt;
    logic [CELL_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [IDX_W-1:0]  tx_idx, tx_idx_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [WIDTH-1:0]  tx_word, tx_word_nxt;
    logic              tx_busy_nxt, sig_out_nxt, bs_out_nxt;
    logic [IDX_W-1:0]  tx_idx_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            gap_cnt  <= '0;
            tx_word  <= '0;
            tx_busy  <= 1'b0;
            sig_out  <= 1'b0;
            bs_out   <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            gap_cnt  <= gap_cnt_nxt;
            tx_word  <= tx_word_nxt;
            tx_busy  <= tx_busy_nxt;
            sig_out  <= sig_out_nxt;
            bs_out   <= bs_out_nxt;
        end
    end

    assign tx_idx_inc = tx_idx + IDX_W'(1);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_idx_nxt   = tx_idx;
        gap_cnt_nxt  = gap_cnt;
        tx_word_nxt  = tx_word;
        tx_busy_nxt  = tx_busy;
        sig_out_nxt  = sig_out;
        bs_out_nxt   = bs_out;
        case (tx_state)
            T_IDLE: begin
                if (tx_start) begin
                    tx_word_nxt  = tx_data;
                    tx_state_nxt = T_SEND;
                    tx_cnt_nxt   = '0;
                    tx_idx_nxt   = '0;
                    tx_busy_nxt  = 1'b1;
                    sig_out_nxt  = 1'b1;
                    bs_out_nxt   = tx_data[0];
                end
            end
            T_SEND: begin
                if (tx_cnt != CELL_LAST) begin
                    tx_cnt_nxt = tx_cnt + CELL_W'(1);
                end else if (tx_idx != IDX_LAST) begin
                    tx_cnt_nxt = '0;
                    tx_idx_nxt = tx_idx_inc;
                    bs_out_nxt = tx_word[tx_idx_inc];
                end else begin
                    tx_state_nxt = T_GAP;
                    tx_cnt_nxt   = '0;
                    tx_idx_nxt   = '0;
                    gap_cnt_nxt  = '0;
                    sig_out_nxt  = 1'b0;
                    bs_out_nxt   = 1'b0;
                end
            end
            T_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    tx_state_nxt = T_IDLE;
                    gap_cnt_nxt  = '0;
                    tx_busy_nxt  = 1'b0;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: tx_state_nxt = T_IDLE;
        endcase
    end

endmodule

// File: tb/tb_slave_uart_link.sv
// Scoreboard bench for slave_uart_link: stimulus pushes expected rx events and
// tx words; free-running monitors check them as the DUT produces them.
module tb_slave_uart_link;

    localparam int unsigned W   = 16;
    localparam int unsigned BIT = 100;
    localparam int unsigned GAP = 100;

    typedef struct {
        logic         is_err;
        logic [W-1:0] data;
    } rx_exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bs_drv = 1'b0, sig_drv = 1'b0, loop = 1'b0;
    logic         bs_in, sig_in;
    logic [W-1:0] rx_data, tx_data = '0;
    logic         rx_valid, rx_err, tx_start = 1'b0, tx_busy, bs_out, sig_out;

    assign bs_in  = loop ? bs_out  : bs_drv;
    assign sig_in = loop ? sig_out : sig_drv;

    slave_uart_link #(.WIDTH(W), .BIT_CLKS(BIT), .GAP_CLKS(GAP)) dut (
        .clk(clk), .rst(rst), .bs_in(bs_in), .sig_in(sig_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .bs_out(bs_out), .sig_out(sig_out)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    rx_exp_t      rx_q[$];
    logic [W-1:0] tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receive-side monitor
    rx_exp_t rx_e;
    always @(negedge clk) begin
        if (!rst && (rx_valid || rx_err)) begin
            if (rx_q.size() == 0) begin
                check("rx_unexpected_event", {30'b0, rx_valid, rx_err}, 32'h0);
            end else begin
                rx_e = rx_q.pop_front();
                check("rx_kind", {30'b0, rx_valid, rx_err}, rx_e.is_err ? 32'h1 : 32'h2);
                check("rx_data", 32'(rx_data), 32'(rx_e.data));
            end
        end
    end

    // Transmit-side monitor: frame length, per-cycle bit value, busy length
    logic         in_frame = 1'b0, busy_active = 1'b0;
    int           frame_cnt = 0, bad_cycles = 0, busy_cnt = 0;
    logic [W-1:0] cur_word = '0;
    always @(negedge clk) begin
        if (rst) begin
            in_frame    = 1'b0;
            busy_active = 1'b0;
            busy_cnt    = 0;
        end else begin
            if (tx_busy) begin
                busy_active = 1'b1;
                busy_cnt++;
            end else if (busy_active) begin
                check("tx_busy_len", 32'(busy_cnt), 32'(W * BIT + GAP));
                busy_active = 1'b0;
                busy_cnt    = 0;
            end
            if (sig_out && !in_frame) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_frame", {31'b0, sig_out}, 32'h0);
                end else begin
                    cur_word = tx_q.pop_front();
                end
                in_frame   = 1'b1;
                frame_cnt  = 0;
                bad_cycles = 0;
            end
            if (in_frame && sig_out) begin
                if (frame_cnt < int'(W * BIT)) begin
                    if (bs_out !== cur_word[frame_cnt / BIT]) bad_cycles++;
                end else begin
                    bad_cycles++;
                end
                frame_cnt++;
            end else if (in_frame) begin
                check("tx_sig_len", 32'(frame_cnt), 32'(W * BIT));
                check("tx_bad_bit_cycles", 32'(bad_cycles), 32'h0);
                check("tx_idle_bs", {31'b0, bs_out}, 32'h0);
                in_frame = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [W-1:0] w, input int nbits);
        @(negedge clk);
        sig_drv = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            bs_drv = w[i];
            repeat (BIT) @(negedge clk);
        end
        sig_drv = 1'b0;
        bs_drv  = 1'b0;
    endtask

    task automatic start_tx(input logic [W-1:0] w);
        @(negedge clk);
        tx_data  = w;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_busy_low();
        int n = 0;
        while (tx_busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy) check("tx_busy_timeout", {31'b0, tx_busy}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},  32'(rx_data), 32'h0);
        check({tag, "_rx_valid"}, {31'b0, rx_valid}, 32'h0);
        check({tag, "_rx_err"},   {31'b0, rx_err}, 32'h0);
        check({tag, "_tx_busy"},  {31'b0, tx_busy}, 32'h0);
        check({tag, "_sig_out"},  {31'b0, sig_out}, 32'h0);
        check({tag, "_bs_out"},   {31'b0, bs_out}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Received frame
        rx_q.push_back('{1'b0, 16'hA5C3});
        send_frame(16'hA5C3, 16);
        repeat (20) @(negedge clk);

        // Frame aborted after 7 bits keeps the previous word
        rx_q.push_back('{1'b1, 16'hA5C3});
        send_frame(16'hFFFF, 7);
        repeat (20) @(negedge clk);

        // Single-bit word transmit
        tx_q.push_back(16'h0001);
        start_tx(16'h0001);
        wait_busy_low();
        repeat (10) @(negedge clk);

        // Request while busy is ignored and tx_data changes do not leak in
        tx_q.push_back(16'hBEEF);
        start_tx(16'hBEEF);
        repeat (49) @(negedge clk);
        check("busy_mid_frame", {31'b0, tx_busy}, 32'h1);
        tx_data  = 16'h1234;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_busy_low();
        repeat (300) @(negedge clk);

        // Loopback
        loop = 1'b1;
        rx_q.push_back('{1'b0, 16'h7E81});
        tx_q.push_back(16'h7E81);
        start_tx(16'h7E81);
        wait_busy_low();
        repeat (10) @(negedge clk);
        loop = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the middle of both directions; sig_in stays high across it
        tx_q.push_back(16'h3C3C);
        fork
            send_frame(16'h00FF, 16);
            start_tx(16'h3C3C);
            begin
                repeat (810) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs("midreset");
                @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("post_reset_busy", {31'b0, tx_busy}, 32'h0);

        rx_q.push_back('{1'b0, 16'h5555});
        send_frame(16'h5555, 16);
        repeat (20) @(negedge clk);

        check("rx_queue_empty", 32'(rx_q.size()), 32'h0);
        check("tx_queue_empty", 32'(tx_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/slave_uart_link.md
SLAVE_UART_LINK -- requirements
Module: slave_uart_link

Interface
REQ-001 Parameter WIDTH, default 16, payload bits per frame.
REQ-002 Parameter BIT_CLKS, default 100, clk cycles per bit cell (even, >=4).
REQ-003 Parameter GAP_CLKS, default 100, minimum idle cycles between transmitted frames.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 bs_in  input  1  serial bitstream from master (asynchronous to clk).
REQ-007 sig_in  input  1  frame-active signal from master (asynchronous to clk).
REQ-008 rx_data  output  WIDTH  last correctly received word.
REQ-009 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 rx_err  output  1  one-cycle pulse on aborted frame.
REQ-011 tx_data  input  WIDTH  word to send, sampled on accepted tx_start.
REQ-012 tx_start  input  1  send request.
REQ-013 tx_busy  output  1  high from accepted tx_start through end of guard gap.
REQ-014 bs_out  output  1  serial bitstream to master.
REQ-015 sig_out  output  1  frame-active signal to master.

Function
REQ-016 Frame format, both directions: sig high for exactly WIDTH*BIT_CLKS cycles; bit i (LSB first) held on bs for cycles [i*BIT_CLKS, (i+1)*BIT_CLKS) counted from sig rise; idle is sig=0, bs=0.
REQ-017 bs_in and sig_in SHALL each pass through a two-flop synchronizer; all receive timing refers to the synchronized signals.
REQ-018 Receiver states: R_IDLE, R_BITS; R_IDLE->R_BITS on synchronized sig_in rising edge (0 in previous cycle, 1 now), resetting bit index and cell counter to 0.
REQ-019 In R_BITS, the cell counter increments every cycle, wraps at BIT_CLKS-1, and advances the bit index on wrap; bit i is sampled when the counter equals BIT_CLKS/2.
REQ-020 On sampling bit WIDTH-1: rx_data loads the assembled word and rx_valid pulses in the next cycle; the receiver returns to R_IDLE.
REQ-021 A synchronized sig_in of 0 in R_BITS before bit WIDTH-1 is sampled SHALL pulse rx_err for one cycle, leave rx_data unchanged, and return to R_IDLE.
REQ-022 While sig_in stays high after a completed frame, no new frame starts until a fresh rising edge occurs.
REQ-023 Transmitter states: T_IDLE, T_SEND, T_GAP; tx_start in T_IDLE is accepted: tx_data is latched, the state goes to T_SEND, and tx_busy goes high in the next cycle.
REQ-024 In T_SEND, sig_out=1 and bs_out=latched bit i, both registered, for exactly WIDTH*BIT_CLKS cycles starting the cycle after acceptance.
REQ-025 After T_SEND: T_GAP for GAP_CLKS cycles with sig_out=0, bs_out=0, tx_busy=1; then T_IDLE with tx_busy=0.
REQ-026 tx_start while tx_busy=1 SHALL be ignored (not queued); changes to tx_data after acceptance do not affect the frame in progress.
REQ-027 Receiver and transmitter are independent; simultaneous rx and tx activity SHALL not interfere.
REQ-028 Counters SHALL be sized ceil(log2) of their maximum terminal value; no arithmetic overflow is permitted at default or larger parameters.

Reset
REQ-029 rst=1 at a clock edge SHALL force, next cycle: rx_data=0, rx_valid=0, rx_err=0, tx_busy=0, sig_out=0, bs_out=0, synchronizers=0, both FSMs idle, all counters 0.
REQ-030 Reset mid-frame SHALL abort silently (no rx_err, no rx_valid); sig_out drops to 0 the cycle after rst.
REQ-031 After rst deasserts, a sig_in already high SHALL not start a frame until it goes low and high again.

Verification
REQ-032 Master frame of 16'hA5C3, BIT_CLKS=100 -> one rx_valid pulse, rx_data=16'hA5C3, rx_err never high.
REQ-033 tx_start with tx_data=16'h0001 -> sig_out high exactly 1600 cycles, bs_out=1 for the first 100 cycles only, tx_busy low exactly 1700 cycles after acceptance.
REQ-034 sig_in dropped after 7 bits of 16'hFFFF -> one rx_err pulse, rx_data keeps its previous value 16'hA5C3.
REQ-035 tx_start pulsed again 50 cycles into a frame with tx_data=16'h1234 -> ignored; the frame still carries the original word, and there is no second frame.
REQ-036 Loopback bs_out->bs_in, sig_out->sig_in, tx_data=16'h7E81 -> rx_data=16'h7E81 with rx_valid while tx continues independently.
REQ-037 rst asserted at bit 8 of rx and tx -> all outputs 0 next cycle; no rx_valid or rx_err; the next full frame 16'h5555 is received correctly.
